riscv_core_cache_mem_arbiter: RTL

RISCV_CORE_CACHE_MEM_ARBITER -- requirements
Module: riscv_core_cache_mem_arbiter

---
 rtl/riscv_core_cache_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/riscv_core_cache_mem_arbiter.sv
// Arbitrates icache refills and dcache refills/writebacks onto one AXI memory port.
// Define RISCV_CORE_ARB_ROUND_ROBIN_EN for alternating priority; otherwise dcache wins ties.
module riscv_core_cache_mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_icache_req,
    input  logic [ADDR_WIDTH-1:0]     i_icache_addr,
    output logic                      o_icache_done,
    output logic [AXI_DATA_WIDTH-1:0] o_icache_block,
    input  logic                      i_dcache_req,
    input  logic                      i_dcache_wr,
    input  logic [ADDR_WIDTH-1:0]     i_dcache_addr,
    input  logic [AXI_DATA_WIDTH-1:0] i_dcache_wb_block,
    output logic                      o_dcache_done,
    output logic [AXI_DATA_WIDTH-1:0] o_dcache_block,
    output logic                      o_mem_req,
    output logic                      o_mem_wr,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [AXI_DATA_WIDTH-1:0] o_mem_wr_block,
    input  logic                      i_mem_done,
    input  logic [AXI_DATA_WIDTH-1:0] i_mem_block
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;
    typedef enum logic {ICACHE, DCACHE} grant_e;

    state_e                    state_q, state_d;
    grant_e                    last_grant_q, last_grant_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [AXI_DATA_WIDTH-1:0] mem_wr_block_q, mem_wr_block_d;
    logic                      pick_d;

    always_comb begin
        pick_d = i_dcache_req;
        if (i_icache_req && i_dcache_req) begin
`ifdef RISCV_CORE_ARB_ROUND_ROBIN_EN
            pick_d = (last_grant_q == ICACHE);
`else
            pick_d = 1'b1;
`endif
        end
    end

    // Request signals are only looked at in IDLE, so the latched command is frozen for the grant.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        mem_req_d      = mem_req_q;
        mem_wr_d       = mem_wr_q;
        mem_addr_d     = mem_addr_q;
        mem_wr_block_d = mem_wr_block_q;
        case (state_q)
            IDLE: begin
                if (i_icache_req || i_dcache_req) begin
                    mem_req_d = 1'b1;
                    if (pick_d) begin
                        state_d        = GRANT_D;
                        last_grant_d   = DCACHE;
                        mem_wr_d       = i_dcache_wr;
                        mem_addr_d     = i_dcache_addr;
                        mem_wr_block_d = i_dcache_wb_block;
                    end else begin
                        state_d        = GRANT_I;
                        last_grant_d   = ICACHE;
                        mem_wr_d       = 1'b0;
                        mem_addr_d     = i_icache_addr;
                        mem_wr_block_d = '0;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (i_mem_done) begin
                    state_d   = RELEASE;
                    mem_req_d = 1'b0;
                end
            end
            RELEASE: state_d = IDLE;
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= ICACHE;
            mem_req_q      <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_block_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            mem_req_q      <= mem_req_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_block_q <= mem_wr_block_d;
        end
    end

    // Done pulses follow i_mem_done combinationally; held low while reset is asserted.
    always_comb begin
        o_icache_done  = i_rst_n && (state_q == GRANT_I) && i_mem_done;
        o_dcache_done  = i_rst_n && (state_q == GRANT_D) && i_mem_done;
        o_icache_block = o_icache_done ? i_mem_block : '0;
        o_dcache_block = o_dcache_done ? i_mem_block : '0;
    end

    assign o_mem_req      = mem_req_q;
    assign o_mem_wr       = mem_wr_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wr_block = mem_wr_block_q;

endmodule
